// File: rtl/text_scan_reader.sv
// text_scan_reader
// Walks the text RAM one console line per RAM word and streams the characters,
// one per valid/ready handshake, to the glyph renderer. A ping-pong line buffer
// lets the next row be fetched while the current one drains, so rows follow each
// other without bubbles. A latched top-row offset gives circular hardware scroll.
module text_scan_reader #(
  parameter int COLUMNS      = 80,
  parameter int ROWS         = 24,
  parameter int CHAR_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ADDR_WIDTH-1:0]         top_row,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic                          ram_rden,
  input  logic [COLUMNS*CHAR_WIDTH-1:0] ram_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHAR_WIDTH-1:0]         out_char,
  output logic [$clog2(COLUMNS)-1:0]    out_col,
  output logic [ADDR_WIDTH-1:0]         out_row,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int COL_W  = $clog2(COLUMNS);
  localparam int LINE_W = COLUMNS * CHAR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   ROWS_EXT  = (ADDR_WIDTH+1)'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] ROWS_A    = ADDR_WIDTH'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(ROWS - 1);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [7:0]            WAIT_LAST = 8'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_REQ  = 3'd1,
    F_WAIT = 3'd2,
    F_CAP  = 3'd3,
    F_HOLD = 3'd4,
    F_DONE = 3'd5
  } fetch_state_t;

  // Circular row add: both operands are already below ROWS, so one
  // conditional subtract at ADDR_WIDTH+1 bits is enough.
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] offs
  );
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= ROWS_EXT) begin
      sum = sum - ROWS_EXT;
    end else begin
      sum = sum;
    end
    return sum[ADDR_WIDTH-1:0];
  endfunction

  fetch_state_t            r_state;
  fetch_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0]   r_top_row_l;
  logic [ADDR_WIDTH-1:0]   r_fetch_row;
  logic [7:0]              r_wait_cnt;

  logic [LINE_W-1:0]       r_fill_buf;
  logic                    r_fill_full;
  logic [ADDR_WIDTH-1:0]   r_fill_row;
  logic [LINE_W-1:0]       r_drain_buf;

  logic                    w_accept;
  logic                    w_col_end;
  logic                    w_drain_free;
  logic                    w_swap;
  logic                    w_last_acc;
  logic                    w_start_ok;
  logic [ADDR_WIDTH-1:0]   w_top_mod;
  logic [COL_W-1:0]        w_col_inc;

  assign w_accept     = out_valid & out_ready;
  assign w_col_end    = (out_col == COL_LAST);
  // The drain slot can take a new line if it is empty or its final column leaves now.
  assign w_drain_free = ~out_valid | (w_accept & w_col_end);
  assign w_swap       = w_drain_free & r_fill_full & ~abort;
  assign w_last_acc   = w_accept & out_last;
  // A start coinciding with the done pulse belongs to the finished frame and is dropped.
  assign w_start_ok   = start & ~done & ~abort;
  assign w_top_mod    = top_row % ROWS_A;
  assign w_col_inc    = out_col + COL_W'(1);

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= F_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch FSM next-state logic; abort always returns to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      F_IDLE: begin
        if (w_start_ok) begin
          w_state_next = F_REQ;
        end else begin
          w_state_next = F_IDLE;
        end
      end
      F_REQ: begin
        w_state_next = F_WAIT;
      end
      F_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = F_CAP;
        end else begin
          w_state_next = F_WAIT;
        end
      end
      F_CAP: begin
        if (r_fetch_row == ROW_LAST) begin
          w_state_next = F_DONE;
        end else begin
          w_state_next = F_HOLD;
        end
      end
      F_HOLD: begin
        if (!r_fill_full) begin
          w_state_next = F_REQ;
        end else begin
          w_state_next = F_HOLD;
        end
      end
      F_DONE: begin
        if (w_last_acc) begin
          w_state_next = F_IDLE;
        end else begin
          w_state_next = F_DONE;
        end
      end
      default: begin
        w_state_next = F_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next = F_IDLE;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Fetch-side registers: RAM request, read-latency counter, row bookkeeping, busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      ram_rden    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      r_top_row_l <= '0;
      r_fetch_row <= '0;
      r_wait_cnt  <= '0;
    end else if (abort) begin
      ram_rden   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        F_IDLE: begin
          if (w_start_ok) begin
            r_top_row_l <= w_top_mod;
            r_fetch_row <= '0;
            busy        <= 1'b1;
          end
        end
        F_REQ: begin
          ram_address <= wrap_add(r_top_row_l, r_fetch_row);
          ram_rden    <= 1'b1;
          r_wait_cnt  <= '0;
        end
        F_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        F_CAP: begin
          ram_rden <= 1'b0;
          if (r_fetch_row != ROW_LAST) begin
            r_fetch_row <= r_fetch_row + ADDR_WIDTH'(1);
          end
        end
        F_DONE: begin
          if (w_last_acc) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Fill buffer: captures the RAM line in F_CAP, released when swapped to the drain side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_buf  <= '0;
      r_fill_full <= 1'b0;
      r_fill_row  <= '0;
    end else if (abort) begin
      r_fill_full <= 1'b0;
    end else if (r_state == F_CAP) begin
      r_fill_buf  <= ram_q;
      r_fill_full <= 1'b1;
      r_fill_row  <= r_fetch_row;
    end else if (w_swap) begin
      r_fill_full <= 1'b0;
    end
  end

  // Drain buffer and registered character stream; outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_buf <= '0;
      out_valid   <= 1'b0;
      out_char    <= '0;
      out_col     <= '0;
      out_row     <= '0;
      out_last    <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_swap) begin
      r_drain_buf <= r_fill_buf;
      out_valid   <= 1'b1;
      out_char    <= r_fill_buf[CHAR_WIDTH-1:0];
      out_col     <= '0;
      out_row     <= r_fill_row;
      out_last    <= (COLUMNS == 1) && (r_fill_row == ROW_LAST);
    end else if (w_accept) begin
      if (w_col_end) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_col  <= w_col_inc;
        out_char <= r_drain_buf[CHAR_WIDTH*int'(w_col_inc) +: CHAR_WIDTH];
        out_last <= (w_col_inc == COL_LAST) && (out_row == ROW_LAST);
      end
    end
  end

endmodule
